spypath_tdc: RTL and testbench

SPYPATH_TDC -- requirements
Module: spypath_tdc

---
 rtl/spypath_pkg.sv | 32 +++
 rtl/spypath_tdc_chain.sv | 28 ++
 rtl/spypath_tdc.sv | 168 ++++++++++++++++
 tb/tb_spypath_tdc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spypath_pkg.sv
// Shared definitions for the spypath delay-chain TDC: FSM states, default
// sizing and the width helpers used by every file in this slice.
package spypath_pkg;

    localparam int DEF_STAGES     = 50;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_SAMPLES    = 8;
    localparam int DEF_SETTLE_CYC = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        CAPTURE,
        ACCUM,
        COMPARE,
        DONE
    } tdcStateT;

    function automatic int cntWidth(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic int log2Ceil(input int n);
        return $clog2(n);
    endfunction

    function automatic int chWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/spypath_tdc_chain.sv
// One tapped delay chain of STAGES spypath cells; every cell output is a tap
// and is kept so the chain survives optimisation.
module spypath_tdc_chain
    import spypath_pkg::*;
#(
    parameter int STAGES = DEF_STAGES
) (
    input  logic              launchIn,
    output logic [STAGES-1:0] taps
);

    (* keep *) logic [STAGES-1:0] stageOut;

    // Taps the launch edge has not reached still show the previous level.
    // Tied to all-ones for hardware; simulation overrides it to model reach.
    logic [STAGES-1:0] arrivedMask;
    assign arrivedMask = '1;

    always_comb begin
        stageOut[0] = launchIn;
        for (int i = 1; i < STAGES; i++) begin
            stageOut[i] = stageOut[i-1];
        end
    end

    assign taps = stageOut ^ ~arrivedMask;

endmodule

// File: rtl/spypath_tdc.sv
// Averaged delay-chain measurement: launches SAMPLES edges down the selected
// chain, sums the tap counts and flags an average outside the golden window.
module spypath_tdc
    import spypath_pkg::*;
#(
    parameter int  STAGES     = DEF_STAGES,
    parameter int  CHANNELS   = DEF_CHANNELS,
    parameter int  SAMPLES    = DEF_SAMPLES,
    parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int CNT_W      = cntWidth(STAGES),
    localparam int SHIFT      = log2Ceil(SAMPLES),
    localparam int ACC_W      = CNT_W + SHIFT,
    localparam int CH_W       = chWidth(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [CNT_W-1:0] golden_min,
    input  logic [CNT_W-1:0] golden_max,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [CNT_W-1:0] avg,
    output logic             trojan_flag,
    output logic             err
);

    localparam int SCNT_W   = (SHIFT > 0) ? SHIFT : 1;
    localparam int SET_LAST = (SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 0;
    localparam int SET_W    = (SET_LAST > 0) ? $clog2(SET_LAST + 1) : 1;

    tdcStateT          state;
    logic [CH_W-1:0]   chLat;
    logic [CNT_W-1:0]  minLat;
    logic [CNT_W-1:0]  maxLat;
    logic [ACC_W-1:0]  acc;
    logic [SCNT_W-1:0] sampleCnt;
    logic [SET_W-1:0]  settleCnt;
    logic [CHANNELS-1:0] launchReg;
    logic [STAGES-1:0] tapBus [CHANNELS];
    logic [STAGES-1:0] capVec;

    logic [CHANNELS-1:0] selOneHot;
    logic                chOk;
    logic [STAGES-1:0]   selTaps;
    logic                launchLevel;
    logic [CNT_W-1:0]    tapCount;
    logic [CNT_W-1:0]    accAvg;

    for (genvar c = 0; c < CHANNELS; c++) begin : gChain
        spypath_tdc_chain #(.STAGES(STAGES)) uChain (
            .launchIn (launchReg[c]),
            .taps     (tapBus[c])
        );
    end

    // Decoding by comparison keeps an out-of-range selection from ever indexing.
    always_comb begin
        selOneHot   = '0;
        selTaps     = '0;
        launchLevel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chLat == CH_W'(c)) begin
                selOneHot[c] = 1'b1;
                selTaps      = tapBus[c];
                launchLevel  = launchReg[c];
            end
        end
    end

    assign chOk = |selOneHot;

    // Popcount of taps matching the launch level, so bubbles are tolerated.
    always_comb begin
        tapCount = '0;
        for (int i = 0; i < STAGES; i++) begin
            tapCount = tapCount + CNT_W'(capVec[i] == launchLevel);
        end
    end

    assign accAvg = acc[ACC_W-1:SHIFT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            trojan_flag <= 1'b0;
            result      <= '0;
            avg         <= '0;
            acc         <= '0;
            sampleCnt   <= '0;
            settleCnt   <= '0;
            capVec      <= '0;
            launchReg   <= '0;
            chLat       <= '0;
            minLat      <= '0;
            maxLat      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        chLat     <= ch_sel;
                        minLat    <= golden_min;
                        maxLat    <= golden_max;
                        acc       <= '0;
                        sampleCnt <= '0;
                        settleCnt <= '0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!chOk) begin
                        err         <= 1'b1;
                        result      <= '0;
                        avg         <= '0;
                        trojan_flag <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (settleCnt == SET_W'(SET_LAST)) begin
                        state <= LAUNCH;
                    end else begin
                        settleCnt <= settleCnt + SET_W'(1);
                    end
                end
                LAUNCH: begin
                    launchReg <= launchReg ^ selOneHot;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    capVec <= selTaps;
                    state  <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(tapCount);
                    if (sampleCnt == SCNT_W'(SAMPLES - 1)) begin
                        state <= COMPARE;
                    end else begin
                        sampleCnt <= sampleCnt + SCNT_W'(1);
                        settleCnt <= '0;
                        state     <= SETTLE;
                    end
                end
                COMPARE: begin
                    result      <= acc;
                    avg         <= accAvg;
                    trojan_flag <= (accAvg < minLat) || (accAvg > maxLat);
                    err         <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spypath_tdc.sv
// Bench for spypath_tdc: per-sample tap reach is injected into each chain and
// results are compared with a sum/average model of the measurement.
module tb_spypath_tdc;

    localparam int STAGES     = 50;
    localparam int CHANNELS   = 4;
    localparam int SAMPLES    = 8;
    localparam int SETTLE_CYC = 4;
    localparam int CNT_W      = $clog2(STAGES + 1);
    localparam int ACC_W      = CNT_W + $clog2(SAMPLES);
    localparam int CH_W       = $clog2(CHANNELS);
    localparam int LAT        = SAMPLES * (SETTLE_CYC + 3) + 2;
    localparam int BUDGET     = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CH_W-1:0]  chSel = '0;
    logic [CNT_W-1:0] goldenMin = '0;
    logic [CNT_W-1:0] goldenMax = '0;
    logic             busy, done, trojanFlag, err;
    logic [ACC_W-1:0] result;
    logic [CNT_W-1:0] avg;

    // A 2-bit select cannot reach an invalid channel, so the error path is
    // exercised on a five-channel instance with a 3-bit select.
    logic             start2 = 1'b0;
    logic [2:0]       chSel2 = '0;
    logic [CNT_W-1:0] goldenMin2 = CNT_W'(10);
    logic [CNT_W-1:0] goldenMax2 = CNT_W'(40);
    logic             busy2, done2, trojan2, err2;
    logic [ACC_W-1:0] result2;
    logic [CNT_W-1:0] avg2;

    logic [STAGES-1:0] maskCh0 = '1;
    logic [STAGES-1:0] maskCh1 = '1;
    logic [STAGES-1:0] maskCh2 = '1;
    logic [STAGES-1:0] maskCh3 = '1;
    logic [STAGES-1:0] sampleMask [SAMPLES];
    logic [ACC_W-1:0]  expQ [$];
    int checkCnt = 0;
    int passCnt  = 0;

    always #5 clk = ~clk;

    spypath_tdc #(
        .STAGES(STAGES), .CHANNELS(CHANNELS), .SAMPLES(SAMPLES), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(chSel),
        .golden_min(goldenMin), .golden_max(goldenMax),
        .busy(busy), .done(done), .result(result), .avg(avg),
        .trojan_flag(trojanFlag), .err(err)
    );

    spypath_tdc #(
        .STAGES(STAGES), .CHANNELS(5), .SAMPLES(SAMPLES), .SETTLE_CYC(SETTLE_CYC)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .ch_sel(chSel2),
        .golden_min(goldenMin2), .golden_max(goldenMax2),
        .busy(busy2), .done(done2), .result(result2), .avg(avg2),
        .trojan_flag(trojan2), .err(err2)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [STAGES-1:0] makeMask(input int count, input bit bubble);
        logic [STAGES-1:0] m;
        int j;
        logic t;
        m = '0;
        for (int i = 0; i < count; i++) m[i] = 1'b1;
        if (bubble) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = m[i]; m[i] = m[j]; m[j] = t;
            end
        end
        return m;
    endfunction

    task automatic fillMasks(input int count, input bit bubble);
        for (int k = 0; k < SAMPLES; k++) sampleMask[k] = makeMask(count, bubble);
    endtask

    task automatic setMask(input int ch, input logic [STAGES-1:0] m);
        case (ch)
            0: maskCh0 = m;
            1: maskCh1 = m;
            2: maskCh2 = m;
            default: maskCh3 = m;
        endcase
    endtask

    // One measurement on the main instance; reach for sample k is applied as
    // soon as the k-th launch toggle of the selected chain is seen.
    task automatic runMeas(input int ch, input int gMin, input int gMax,
                           input int abortAt, input bit pokeBusy);
        int cycles, k, lat, expSum, expAvg;
        bit expTroj;
        logic [CHANNELS-1:0] prevL;
        expSum = 0;
        for (int s = 0; s < SAMPLES; s++) expSum += $countones(sampleMask[s]);
        expAvg  = expSum / SAMPLES;
        expTroj = (expAvg < gMin) || (expAvg > gMax);
        expQ.push_back(ACC_W'(expSum));
        setMask(ch, sampleMask[0]);

        @(negedge clk);
        chSel = CH_W'(ch); goldenMin = CNT_W'(gMin); goldenMax = CNT_W'(gMax); start = 1'b1;
        prevL = dut.launchReg; k = 0; lat = 0; cycles = 0;
        while (cycles < BUDGET && lat == 0) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (pokeBusy && (cycles == 10 || cycles == 33)) begin
                start = 1'b1; chSel = CH_W'(chSel + 1'b1); goldenMin = '0; goldenMax = '0;
            end
            if (abortAt != 0 && cycles == abortAt) begin
                rst_n = 1'b0;
                #1;
                checkVal("rstBusy", 32'(busy), 0);
                checkVal("rstLaunch", 32'(dut.launchReg), 0);
                checkVal("rstDone", 32'(done), 0);
                checkVal("rstResult", 32'(result), 0);
                checkVal("rstAvg", 32'(avg), 0);
                checkVal("rstTrojan", 32'(trojanFlag), 0);
                @(negedge clk);
                rst_n = 1'b1; start = 1'b0;
                void'(expQ.pop_back());
                return;
            end
            if (dut.launchReg[ch] != prevL[ch]) begin
                if (k < SAMPLES) setMask(ch, sampleMask[k]);
                k++;
                prevL = dut.launchReg;
            end
            if (done) lat = cycles;
        end
        checkVal("latency", 32'(lat), 32'(LAT));
        checkVal("result", 32'(result), 32'(expQ.pop_front()));
        checkVal("avg", 32'(avg), 32'(expAvg));
        checkVal("trojan", 32'(trojanFlag), 32'(expTroj));
        checkVal("err", 32'(err), 0);
        checkVal("busyInDone", 32'(busy), 1);
        start = 1'b1;
        chSel = CH_W'($urandom_range(CHANNELS - 1, 0));
        @(negedge clk);
        start = 1'b0;
        checkVal("startInDoneIgnored", 32'(busy), 0);
        checkVal("donePulse", 32'(done), 0);
        checkVal("resultHold", 32'(result), 32'(expSum));
        checkVal("launchBack", 32'(dut.launchReg[ch]), 32'(SAMPLES % 2));
    endtask

    task automatic runDut2(input int ch, input int expLat, input bit expErr,
                           input int expRes, input bit expTroj);
        int cycles, lat;
        @(negedge clk);
        chSel2 = 3'(ch); start2 = 1'b1;
        cycles = 0; lat = 0;
        while (cycles < BUDGET && lat == 0) begin
            @(negedge clk);
            cycles++;
            start2 = 1'b0;
            if (done2) lat = cycles;
        end
        checkVal("d2Latency", 32'(lat), 32'(expLat));
        checkVal("d2Err", 32'(err2), 32'(expErr));
        checkVal("d2Result", 32'(result2), 32'(expRes));
        checkVal("d2Avg", 32'(avg2), 32'(expRes / SAMPLES));
        checkVal("d2Trojan", 32'(trojan2), 32'(expTroj));
        @(negedge clk);
        checkVal("d2Idle", 32'(busy2), 0);
        checkVal("d2ErrHold", 32'(err2), 32'(expErr));
    endtask

    initial begin
        int gA, gB, ch;
        force dut.gChain[0].uChain.arrivedMask = maskCh0;
        force dut.gChain[1].uChain.arrivedMask = maskCh1;
        force dut.gChain[2].uChain.arrivedMask = maskCh2;
        force dut.gChain[3].uChain.arrivedMask = maskCh3;

        repeat (3) @(negedge clk);
        checkVal("resetBusy", 32'(busy), 0);
        checkVal("resetDone", 32'(done), 0);
        checkVal("resetErr", 32'(err), 0);
        checkVal("resetResult", 32'(result), 0);
        checkVal("resetAvg", 32'(avg), 0);
        checkVal("resetLaunch", 32'(dut.launchReg), 0);
        rst_n = 1'b1;
        @(negedge clk);

        fillMasks(20, 1'b0); runMeas(1, 18, 22, 0, 1'b0);
        fillMasks(25, 1'b0); runMeas(1, 18, 22, 0, 1'b0);
        for (int k = 0; k < SAMPLES; k++) sampleMask[k] = makeMask((k % 2 == 0) ? 19 : 21, 1'b0);
        runMeas(1, 18, 22, 0, 1'b0);
        for (int k = 0; k < SAMPLES; k++)
            for (int i = 0; i < STAGES; i++) sampleMask[k][i] = (i < 40) && (i % 2 == 0);
        runMeas(1, 18, 22, 0, 1'b0);

        fillMasks(18, 1'b0); runMeas(2, 18, 22, 0, 1'b0);
        fillMasks(22, 1'b0); runMeas(3, 18, 22, 0, 1'b0);
        fillMasks(17, 1'b0); runMeas(0, 18, 22, 0, 1'b0);
        fillMasks(23, 1'b0); runMeas(0, 18, 22, 0, 1'b0);
        fillMasks(20, 1'b0); runMeas(1, 22, 18, 0, 1'b0);
        fillMasks(0, 1'b0);  runMeas(2, 0, 0, 0, 1'b0);
        fillMasks(STAGES, 1'b0); runMeas(3, 0, STAGES, 0, 1'b0);

        fillMasks(20, 1'b0); runMeas(1, 18, 22, 30, 1'b1);
        fillMasks(20, 1'b1); runMeas(2, 18, 22, 0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            ch = $urandom_range(CHANNELS - 1, 0);
            for (int k = 0; k < SAMPLES; k++)
                sampleMask[k] = makeMask($urandom_range(STAGES, 0), 1'($urandom_range(1, 0)));
            gA = $urandom_range(STAGES, 0);
            gB = $urandom_range(STAGES, 0);
            if ($urandom_range(3, 0) != 0 && gA > gB) begin
                int t; t = gA; gA = gB; gB = t;
            end
            runMeas(ch, gA, gB, 0, 1'($urandom_range(1, 0)));
        end

        runDut2(4, LAT, 1'b0, SAMPLES * STAGES, 1'b1);
        runDut2(5, 2, 1'b1, 0, 1'b0);
        runDut2(7, 2, 1'b1, 0, 1'b0);
        runDut2(0, LAT, 1'b0, SAMPLES * STAGES, 1'b1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
